// File: rtl/alu_issue_ctrl.sv
// Issue controller for the add/bool/shift ALU units: schedules writeback slots so the
// registered result mux never sees two completions in the same cycle.
module alu_issue_ctrl #(
    parameter int unsigned SHIFT_LAT = 3,
    parameter int unsigned TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic [1:0]       req_unit,
    input  logic [TAG_W-1:0] req_tag,
    output logic             req_ready,
    output logic             issue_add,
    output logic             issue_bool,
    output logic             issue_shift,
    output logic [2:0]       mux_en,
    output logic             rsp_valid,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             err_illegal,
    output logic             busy
);

    localparam int unsigned LAT_W = $clog2(SHIFT_LAT + 1);
    localparam int unsigned IDX_W = $clog2(SHIFT_LAT);

    localparam logic [1:0] UNIT_ADD   = 2'b00;
    localparam logic [1:0] UNIT_BOOL  = 2'b01;
    localparam logic [1:0] UNIT_SHIFT = 2'b10;
    localparam logic [1:0] UNIT_ILL   = 2'b11;

    // Reservation slots; the top slot R[SHIFT_LAT] can never be set, so it is not stored.
    logic [SHIFT_LAT-1:0] r_vld;
    logic [1:0]           r_unit [SHIFT_LAT];
    logic [TAG_W-1:0]     r_tag  [SHIFT_LAT];
    logic                 r_rsp_valid;
    logic [TAG_W-1:0]     r_rsp_tag;
    logic                 r_err;

    logic [SHIFT_LAT-1:0] w_nxt_vld;
    logic [1:0]           w_nxt_unit [SHIFT_LAT];
    logic [TAG_W-1:0]     w_nxt_tag  [SHIFT_LAT];
    logic [SHIFT_LAT:0]   w_vld_ext;
    logic [LAT_W-1:0]     w_lat;
    logic [IDX_W-1:0]     w_slot;
    logic                 w_legal;
    logic                 w_accept;

    assign w_legal   = (req_unit != UNIT_ILL);
    assign w_lat     = (req_unit == UNIT_SHIFT) ? LAT_W'(SHIFT_LAT) : LAT_W'(1);
    assign w_slot    = IDX_W'(w_lat - LAT_W'(1));
    assign w_vld_ext = {1'b0, r_vld};

    // A legal op may go only if the slot that becomes R[L-1] next cycle is free now (R[L]).
    assign req_ready   = rst_n && (!w_legal || !w_vld_ext[w_lat]);
    assign w_accept    = req_valid && req_ready;
    assign issue_add   = w_accept && (req_unit == UNIT_ADD);
    assign issue_bool  = w_accept && (req_unit == UNIT_BOOL);
    assign issue_shift = w_accept && (req_unit == UNIT_SHIFT);

    assign rsp_valid   = r_rsp_valid;
    assign rsp_tag     = r_rsp_tag;
    assign err_illegal = r_err;
    assign busy        = (|r_vld) || r_rsp_valid;

    // Result mux select decoded from the slot that writes back this cycle.
    always_comb begin
        mux_en = 3'b000;
        if (r_vld[0]) begin
            case (r_unit[0])
                UNIT_ADD:   mux_en = 3'b001;
                UNIT_BOOL:  mux_en = 3'b010;
                UNIT_SHIFT: mux_en = 3'b100;
                default:    mux_en = 3'b000;
            endcase
        end
    end

    // Shift reservations down one slot and insert the newly accepted op at L-1.
    always_comb begin
        w_nxt_vld = '0;
        for (int k = 0; k < int'(SHIFT_LAT); k++) begin
            w_nxt_unit[k] = '0;
            w_nxt_tag[k]  = '0;
        end
        for (int k = 0; k < int'(SHIFT_LAT) - 1; k++) begin
            w_nxt_vld[k]  = r_vld[k+1];
            w_nxt_unit[k] = r_unit[k+1];
            w_nxt_tag[k]  = r_tag[k+1];
        end
        if (w_accept && w_legal) begin
            w_nxt_vld[w_slot]  = 1'b1;
            w_nxt_unit[w_slot] = req_unit;
            w_nxt_tag[w_slot]  = req_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_tag   <= '0;
            r_err       <= 1'b0;
            for (int k = 0; k < int'(SHIFT_LAT); k++) begin
                r_unit[k] <= '0;
                r_tag[k]  <= '0;
            end
        end else begin
            r_vld       <= w_nxt_vld;
            r_rsp_valid <= r_vld[0];
            r_rsp_tag   <= r_vld[0] ? r_tag[0] : '0;
            r_err       <= w_accept && !w_legal;
            for (int k = 0; k < int'(SHIFT_LAT); k++) begin
                r_unit[k] <= w_nxt_unit[k];
                r_tag[k]  <= w_nxt_tag[k];
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed scenarios then randomized traffic, all checked
// against a model that tracks each op by its absolute writeback cycle.
module tb_alu_issue_ctrl;

    localparam int unsigned SHIFT_LAT = 3;
    localparam int unsigned TAG_W     = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic [1:0]       req_unit;
    logic [TAG_W-1:0] req_tag;
    logic             req_ready;
    logic             issue_add, issue_bool, issue_shift;
    logic [2:0]       mux_en;
    logic             rsp_valid;
    logic [TAG_W-1:0] rsp_tag;
    logic             err_illegal;
    logic             busy;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.SHIFT_LAT(SHIFT_LAT), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_unit(req_unit),
        .req_tag(req_tag), .req_ready(req_ready), .issue_add(issue_add),
        .issue_bool(issue_bool), .issue_shift(issue_shift), .mux_en(mux_en),
        .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .err_illegal(err_illegal), .busy(busy)
    );

    typedef struct {
        int               wb;
        logic [1:0]       unit;
        logic [TAG_W-1:0] tag;
    } op_t;

    op_t  q[$];
    int   cyc;
    int   n_vec;
    int   n_err;
    logic err_exp;
    bit   rst_prev;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    function automatic int lat_of(input logic [1:0] u);
        return (u == 2'b10) ? int'(SHIFT_LAT) : 1;
    endfunction

    // One clock cycle: drive, check mid-cycle, then advance the model at the edge.
    task automatic step(input bit v, input logic [1:0] u, input logic [TAG_W-1:0] t,
                        input bit r, output bit acc);
        logic       exp_ready;
        logic [2:0] exp_mux;
        logic       exp_rv;
        logic [TAG_W-1:0] exp_tag;
        bit         taken;
        rst_n = r; req_valid = v; req_unit = u; req_tag = t;
        @(negedge clk);
        taken = 1'b0;
        exp_mux = 3'b000; exp_rv = 1'b0; exp_tag = '0;
        foreach (q[i]) begin
            if (q[i].wb == cyc + lat_of(u)) taken = 1'b1;
            if (q[i].wb == cyc) exp_mux = 3'b001 << q[i].unit;
            if (q[i].wb == cyc - 1) begin exp_rv = 1'b1; exp_tag = q[i].tag; end
        end
        exp_ready = r && ((u == 2'b11) || !taken);
        acc = v && exp_ready;
        chk("req_ready",   32'(req_ready),   32'(exp_ready));
        chk("issue_add",   32'(issue_add),   32'(acc && u == 2'b00));
        chk("issue_bool",  32'(issue_bool),  32'(acc && u == 2'b01));
        chk("issue_shift", 32'(issue_shift), 32'(acc && u == 2'b10));
        chk("mux_en",      32'(mux_en),      32'(exp_mux));
        chk("rsp_valid",   32'(rsp_valid),   32'(exp_rv));
        if (exp_rv || rst_prev) chk("rsp_tag", 32'(rsp_tag), 32'(exp_tag));
        chk("err_illegal", 32'(err_illegal), 32'(err_exp));
        chk("busy",        32'(busy),        32'(q.size() != 0));
        @(posedge clk);
        if (!r) begin
            q.delete();
            err_exp = 1'b0;
        end else begin
            err_exp = acc && (u == 2'b11);
            if (acc && u != 2'b11) q.push_back('{wb: cyc + lat_of(u), unit: u, tag: t});
        end
        rst_prev = !r;
        cyc++;
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].wb < cyc - 1) q.delete(i);
        #1;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, '0, 1'b1, a);
    endtask

    initial begin
        bit acc;
        bit pend;
        bit v, r;
        logic [1:0] u;
        logic [TAG_W-1:0] t;
        int pick;
        n_vec = 0; n_err = 0; cyc = 0; err_exp = 1'b0; rst_prev = 1'b1;
        rst_n = 1'b0; req_valid = 1'b0; req_unit = 2'b00; req_tag = '0;
        @(posedge clk); #1;
        step(1'b0, 2'b00, '0, 1'b0, acc);
        idle(1);

        // Single add, back-to-back adds, shift/add collision, out-of-order return
        step(1'b1, 2'b00, 4'd5, 1'b1, acc); idle(3);
        step(1'b1, 2'b00, 4'd1, 1'b1, acc);
        step(1'b1, 2'b00, 4'd2, 1'b1, acc);
        step(1'b1, 2'b00, 4'd3, 1'b1, acc); idle(3);
        step(1'b1, 2'b10, 4'd7, 1'b1, acc); idle(1);
        step(1'b1, 2'b00, 4'd8, 1'b1, acc);
        chk("collide_stall", 32'(acc), 32'(0));
        step(1'b1, 2'b00, 4'd8, 1'b1, acc);
        chk("collide_retry", 32'(acc), 32'(1));
        idle(3);
        step(1'b1, 2'b10, 4'd9, 1'b1, acc);
        step(1'b1, 2'b01, 4'd4, 1'b1, acc); idle(4);
        // Illegal op, then reset with a shift in flight
        step(1'b1, 2'b11, 4'd6, 1'b1, acc); idle(3);
        step(1'b1, 2'b10, 4'd11, 1'b1, acc);
        step(1'b1, 2'b01, 4'd12, 1'b0, acc);
        idle(5);

        pend = 1'b0; v = 1'b0; u = 2'b00; t = '0;
        for (int n = 0; n < 3000; n++) begin
            if (!pend) begin
                v = ($urandom_range(0, 99) < 70);
                pick = $urandom_range(0, 99);
                u = (pick < 40) ? 2'b00 : (pick < 65) ? 2'b01 : (pick < 95) ? 2'b10 : 2'b11;
                t = TAG_W'($urandom);
            end
            r = ($urandom_range(0, 99) >= 2);
            step(v, u, t, r, acc);
            pend = v && !acc && r;
        end
        idle(SHIFT_LAT + 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 The block SHALL have parameter SHIFT_LAT, default 3 (legal 2..7): shifter result latency in cycles from issue.
REQ-002 The block SHALL have parameter TAG_W, default 4: width of the request/response tag.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, synchronous and active-low; sampled on posedge clk only.
REQ-005 req_valid  input  1  requester presents an operation.
REQ-006 req_unit  input  2  00 add, 01 bool, 10 shift, 11 illegal.
REQ-007 req_tag  input  TAG_W  requester tag, returned with the result.
REQ-008 req_ready  output  1  controller accepts this cycle; accept = req_valid && req_ready.
REQ-009 issue_add, issue_bool, issue_shift  output  1 each  start pulses to the adder, boolean and shifter units.
REQ-010 mux_en  output  3  one-hot select to the registered result mux; bit0 add, bit1 bool, bit2 shift.
REQ-011 rsp_valid  output  1  the result mux output holds a completed result this cycle.
REQ-012 rsp_tag  output  TAG_W  tag of that result.
REQ-013 err_illegal  output  1  one-cycle pulse for an accepted illegal op.
REQ-014 busy  output  1  any accepted op not yet reported on rsp_valid.

Function
REQ-015 Latency L SHALL be 1 for add and bool, SHIFT_LAT for shift; the units are fully pipelined, so a new op of any unit may issue every cycle.
REQ-016 issue_x SHALL be combinational: high in the accept cycle T iff the accepted req_unit selects unit x; at most one issue_x is high per cycle.
REQ-017 The block SHALL keep a writeback reservation vector R[0..SHIFT_LAT], where R[k] means mux_en is driven k cycles from now; each slot stores its unit and tag.
REQ-018 Each cycle R SHALL shift down by one, and an accept with latency L SHALL set slot L-1 of the next-cycle vector.
REQ-019 req_ready SHALL be 1 for illegal ops; for legal ops it SHALL be !R[L] with L taken from req_unit; it is combinational from req_unit and state, and 0 while rst_n is low.
REQ-020 An op accepted in cycle T SHALL drive mux_en to its unit's one-hot in cycle T+L, with rsp_valid=1 and rsp_tag=req_tag in cycle T+L+1.
REQ-021 mux_en SHALL be one-hot or zero in every cycle; two writebacks in the same cycle SHALL never occur.
REQ-022 Simultaneous events: an accept in the same cycle as a writeback is legal; the shift-down and the new reservation both take effect.
REQ-023 Results SHALL return in writeback order, not acceptance order; a later add may complete before an earlier shift.
REQ-024 An accepted illegal op SHALL issue nothing, reserve nothing and produce no rsp_valid; err_illegal pulses in cycle T+1.
REQ-025 A request not accepted SHALL cause no state change; the requester holds it until accepted.
REQ-026 busy SHALL be 1 when any R slot is set or rsp_valid is 1.

Reset
REQ-027 While rst_n=0 at posedge clk, the block SHALL clear R and all stored units and tags.
REQ-028 The cycle after such an edge, all outputs SHALL be 0: mux_en=000, rsp_valid=0, rsp_tag=0, err_illegal=0, busy=0, issue_*=0.
REQ-029 Ops in flight at reset SHALL be discarded silently, with no later rsp_valid for them.
REQ-030 req_ready SHALL be 0 while rst_n=0.
REQ-031 The first accept SHALL be possible in the first cycle with rst_n=1.

Verification (SHIFT_LAT=3)
REQ-032 Add, tag 5, accepted cycle 0 -> issue_add cycle 0; mux_en=001 cycle 1; rsp_valid=1 with rsp_tag=5 cycle 2.
REQ-033 Adds tags 1,2,3 in cycles 0,1,2 -> req_ready stays 1; mux_en=001 cycles 1-3; rsp tags 1,2,3 in cycles 2-4.
REQ-034 Shift tag 7 cycle 0, add tag 8 offered cycle 2 -> req_ready=0 cycle 2; add accepted cycle 3; mux_en=100 cycle 3 and 001 cycle 4; rsp tag 7 cycle 4 and tag 8 cycle 5.
REQ-035 Shift tag 9 cycle 0, bool tag 4 cycle 1 -> mux_en=010 cycle 2 and 100 cycle 3; rsp tag 4 cycle 3 and tag 9 cycle 4.
REQ-036 req_unit=11 tag 6 cycle 0 -> req_ready=1; no issue_*; err_illegal=1 cycle 1; no rsp_valid.
REQ-037 Shift accepted cycle 0, rst_n=0 at cycle-1 edge -> from cycle 2 all outputs 0 and busy=0; no rsp_valid ever appears for that shift.
